// File: rtl/purchase_pkg.sv
// Shared types and constants for the purchase arbiter and its helpers.
// Pure declarations: no logic, no latency, no flow control.
package purchase_pkg;

  localparam int CREDIT_W = 8;

  typedef enum logic [1:0] {
    PROD_APPLE  = 2'd0,
    PROD_BANANA = 2'd1,
    PROD_CARROT = 2'd2,
    PROD_DATE   = 2'd3
  } prod_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Indexed by product code.
  localparam logic [CREDIT_W-1:0] PRICE [4] = '{8'd75, 8'd20, 8'd30, 8'd40};

endpackage

// File: rtl/rr_picker.sv
// Round-robin pick: first set request at or after ptr_i (mod N), as one-hot and index.
// Purely combinational, zero latency; no flow control (vld_o low when nothing requests).
module rr_picker #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          vld_o
);

  // Walk from the farthest offset down so the nearest requester is written last and wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    vld_o   = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % N]) begin
        grant_o                             = '0;
        grant_o[(int'(ptr_i) + k) % N]      = 1'b1;
        idx_o                               = IW'((int'(ptr_i) + k) % N);
        vld_o                               = 1'b1;
      end
    end
  end

endmodule

// File: rtl/purchase_arbiter.sv
// Shares one purchaseManager among N kiosks round-robin, with a credit wallet per kiosk.
// One purchase per RESP_LAT+3 cycles; kiosks hold req until ack, deposits are always accepted.
module purchase_arbiter
  import purchase_pkg::*;
#(
  parameter int N        = 4,
  parameter int RESP_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          req,
  input  logic [2*N-1:0]        req_product,
  input  logic                  dep_valid,
  input  logic [$clog2(N)-1:0]  dep_id,
  input  logic [CREDIT_W-1:0]   dep_amount,
  output logic [N-1:0]          ack,
  output logic                  ack_ok,
  output logic                  ack_err,
  output logic                  busy,
  output logic                  pm_buy,
  output logic [1:0]            pm_product,
  output logic [CREDIT_W-1:0]   pm_credit,
  input  logic                  pm_apple,
  input  logic                  pm_banana,
  input  logic                  pm_carrot,
  input  logic                  pm_date,
  input  logic                  pm_error
);

  localparam int IW = $clog2(N);

  state_e                state_q, state_d;
  logic [2:0]            wait_cnt_q;
  logic [IW-1:0]         gid_q, rr_ptr_q;
  logic [N-1:0]          gnt_q;
  logic [N-1:0]          ack_q;
  logic                  ack_ok_q, ack_err_q, busy_q, pm_buy_q;
  logic [1:0]            pm_product_q;
  logic [CREDIT_W-1:0]   pm_credit_q;
  logic [CREDIT_W-1:0]   wallet_q [N];
  logic [CREDIT_W-1:0]   wallet_d [N];

  logic [N-1:0]          pick_grant;
  logic [IW-1:0]         pick_idx;
  logic                  pick_vld;
  logic                  wait_last;
  logic                  resp_ok;
  logic                  deduct;
  logic [3:0]            fruit;
  logic [9:0]            sum;

  rr_picker #(.N(N), .IW(IW)) u_rr_picker (
    .req_i   (req),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .vld_o   (pick_vld)
  );

  assign wait_last = (wait_cnt_q == 3'(RESP_LAT - 1));
  assign fruit     = {pm_date, pm_carrot, pm_banana, pm_apple};
  assign resp_ok   = !pm_error && (fruit == (4'b0001 << pm_product_q));
  assign deduct    = (state_q == ST_DONE) && ack_ok_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_vld) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  if (wait_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // 10-bit signed-style intermediate: bit 9 flags underflow, bit 8 flags overflow.
  always_comb begin
    sum = '0;
    for (int i = 0; i < N; i++) begin
      sum = {2'b00, wallet_q[i]};
      if (dep_valid && (int'(dep_id) == i)) sum = sum + {2'b00, dep_amount};
      if (deduct && (int'(gid_q) == i))     sum = sum - {2'b00, PRICE[pm_product_q]};
      if (sum[9])      wallet_d[i] = '0;
      else if (sum[8]) wallet_d[i] = '1;
      else             wallet_d[i] = sum[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= '0;
      gid_q        <= '0;
      gnt_q        <= '0;
      rr_ptr_q     <= '0;
      ack_q        <= '0;
      ack_ok_q     <= 1'b0;
      ack_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      pm_buy_q     <= 1'b0;
      pm_product_q <= '0;
      pm_credit_q  <= '0;
      for (int i = 0; i < N; i++) wallet_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      busy_q     <= (state_d != ST_IDLE);
      pm_buy_q   <= (state_d == ST_ISSUE);
      wait_cnt_q <= (state_q == ST_WAIT) ? wait_cnt_q + 3'd1 : 3'd0;
      ack_q      <= '0;
      ack_ok_q   <= 1'b0;
      ack_err_q  <= 1'b0;

      // Credit is snapshotted here so later deposits do not affect this purchase.
      if (state_q == ST_IDLE && pick_vld) begin
        gid_q        <= pick_idx;
        gnt_q        <= pick_grant;
        pm_product_q <= req_product[{pick_idx, 1'b0} +: 2];
        pm_credit_q  <= wallet_q[pick_idx];
      end

      if (state_q == ST_WAIT && wait_last) begin
        ack_q     <= gnt_q;
        ack_ok_q  <= resp_ok;
        ack_err_q <= !resp_ok;
      end

      if (state_q == ST_DONE)
        rr_ptr_q <= (gid_q == IW'(N - 1)) ? '0 : gid_q + 1'b1;

      for (int i = 0; i < N; i++) wallet_q[i] <= wallet_d[i];
    end
  end

  assign ack        = ack_q;
  assign ack_ok     = ack_ok_q;
  assign ack_err    = ack_err_q;
  assign busy       = busy_q;
  assign pm_buy     = pm_buy_q;
  assign pm_product = pm_product_q;
  assign pm_credit  = pm_credit_q;

endmodule

// File: tb/tb_purchase_arbiter.sv
// Directed bench for purchase_arbiter (N=4, RESP_LAT=1) with a behavioural purchaseManager.
// Wallet contents are observed through pm_credit on later purchases.
module tb_purchase_arbiter;
  import purchase_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  req_product;
  logic        dep_valid;
  logic [1:0]  dep_id;
  logic [7:0]  dep_amount;
  logic [3:0]  ack;
  logic        ack_ok, ack_err, busy, pm_buy;
  logic [1:0]  pm_product;
  logic [7:0]  pm_credit;
  logic        pm_apple, pm_banana, pm_carrot, pm_date, pm_error;

  int n_checks = 0;
  int n_errors = 0;
  int pm_mode  = 0;  // 0 normal, 1 force error, 2 apple+banana, 3 force success

  int          r_nb, r_bc, r_ac;
  logic [3:0]  r_ack;
  logic        r_ok, r_err;
  logic [7:0]  r_cr;

  logic [3:0]  rr_ack [8];
  logic [7:0]  rr_cr  [8];
  int          rr_cyc [8];
  int          price  [4] = '{75, 20, 30, 40};

  always #5 clk = ~clk;

  purchase_arbiter #(.N(4), .RESP_LAT(1)) dut (
    .clk(clk), .reset(reset), .req(req), .req_product(req_product),
    .dep_valid(dep_valid), .dep_id(dep_id), .dep_amount(dep_amount),
    .ack(ack), .ack_ok(ack_ok), .ack_err(ack_err), .busy(busy),
    .pm_buy(pm_buy), .pm_product(pm_product), .pm_credit(pm_credit),
    .pm_apple(pm_apple), .pm_banana(pm_banana), .pm_carrot(pm_carrot),
    .pm_date(pm_date), .pm_error(pm_error)
  );

  // purchaseManager stand-in: answers in the cycle after buy.
  always @(posedge clk) begin
    {pm_apple, pm_banana, pm_carrot, pm_date, pm_error} <= 5'b0;
    if (pm_buy) begin
      case (pm_mode)
        1: pm_error <= 1'b1;
        2: begin pm_apple <= 1'b1; pm_banana <= 1'b1; end
        default: begin
          if (pm_mode == 3 || int'(pm_credit) >= price[pm_product]) begin
            pm_apple  <= (pm_product == 2'd0);
            pm_banana <= (pm_product == 2'd1);
            pm_carrot <= (pm_product == 2'd2);
            pm_date   <= (pm_product == 2'd3);
          end else pm_error <= 1'b1;
        end
      endcase
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic deposit(input logic [1:0] id, input logic [7:0] amt);
    dep_valid = 1'b1; dep_id = id; dep_amount = amt;
    @(negedge clk);
    dep_valid = 1'b0;
  endtask

  // Waits (bounded) for an ack; optionally deposits during the DONE cycle.
  task automatic wait_ack(input logic [7:0] dd_amt, input logic [1:0] dd_id);
    bit got = 0;
    r_nb = 0; r_bc = 0; r_ac = 0; r_ack = '0; r_ok = 0; r_err = 0; r_cr = '0;
    for (int c = 1; c <= 30 && !got; c++) begin
      @(negedge clk);
      if (pm_buy) begin r_nb++; r_cr = pm_credit; r_bc = c; end
      if (ack != '0) begin got = 1; r_ack = ack; r_ok = ack_ok; r_err = ack_err; r_ac = c; end
    end
    req = '0;
    if (!got) check("ack_timeout", 0, 1);
    if (dd_amt != 8'd0) deposit(dd_id, dd_amt);
  endtask

  task automatic buy(input int k, input logic [1:0] p, input int mode, input logic [7:0] dd_amt);
    pm_mode = mode;
    req_product[2*k +: 2] = p;
    req[k] = 1'b1;
    wait_ack(dd_amt, 2'(k));
  endtask

  initial begin
    reset = 1'b1; req = '0; req_product = '0;
    dep_valid = 1'b0; dep_id = '0; dep_amount = '0;
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(ack), 0);
    check("rst_ack_ok", 32'(ack_ok), 0);
    check("rst_ack_err", 32'(ack_err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pm_buy", 32'(pm_buy), 0);
    check("rst_pm_product", 32'(pm_product), 0);
    check("rst_pm_credit", 32'(pm_credit), 0);
    reset = 1'b0;

    // Single buy: 165 - 75 = 90
    deposit(2'd0, 8'd165);
    buy(0, PROD_APPLE, 0, 8'd0);
    check("buy0_credit", 32'(r_cr), 165);
    check("buy0_nbuy", r_nb, 1);
    check("buy0_buy_cycle", r_bc, 1);
    check("buy0_ack_cycle", r_ac, 3);
    check("buy0_ack", 32'(r_ack), 4'b0001);
    check("buy0_ok", 32'(r_ok), 1);
    check("buy0_err", 32'(r_err), 0);
    buy(0, PROD_BANANA, 0, 8'd0);
    check("wallet0_after_apple", 32'(r_cr), 90);

    // Refusal: wallet1 stays 10
    deposit(2'd1, 8'd10);
    buy(1, PROD_DATE, 1, 8'd0);
    check("refuse_ack", 32'(r_ack), 4'b0010);
    check("refuse_ok", 32'(r_ok), 0);
    check("refuse_err", 32'(r_err), 1);
    buy(1, PROD_BANANA, 0, 8'd0);
    check("wallet1_after_refuse", 32'(r_cr), 10);

    // Round-robin from a clean reset, all wallets at 255
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) deposit(2'(i), 8'd255);
    pm_mode = 0;
    req_product = 8'h55;
    req = 4'b1111;
    begin
      int na = 0;
      int nbuy = 0;
      for (int c = 1; c <= 80 && na < 8; c++) begin
        @(negedge clk);
        if (pm_buy && nbuy < 8) begin rr_cr[nbuy] = pm_credit; nbuy++; end
        if (ack != '0) begin rr_ack[na] = ack; rr_cyc[na] = c; na++; end
      end
      req = '0;
      check("rr_ack_count", na, 8);
    end
    for (int i = 0; i < 8; i++) begin
      check("rr_ack_order", 32'(rr_ack[i]), 32'(4'b0001 << (i % 4)));
      check("rr_credit", 32'(rr_cr[i]), (i < 4) ? 255 : 235);
      if (i > 0) check("rr_ack_spacing", rr_cyc[i] - rr_cyc[i-1], 4);
    end

    // Deposit saturation (215+250) and deposit colliding with a deduction
    deposit(2'd2, 8'd250);
    buy(2, PROD_CARROT, 0, 8'd5);
    check("sat_credit", 32'(r_cr), 255);
    check("carrot_ok", 32'(r_ok), 1);
    buy(2, PROD_BANANA, 0, 8'd0);
    check("collision_credit", 32'(r_cr), 230);

    // Malformed response: two fruit lines
    buy(3, PROD_APPLE, 2, 8'd0);
    check("malformed_ack", 32'(r_ack), 4'b1000);
    check("malformed_err", 32'(r_err), 1);
    check("malformed_ok", 32'(r_ok), 0);
    buy(3, PROD_BANANA, 0, 8'd0);
    check("malformed_no_deduct", 32'(r_cr), 215);

    // Reset during WAIT
    @(negedge clk);
    pm_mode = 0;
    req_product = 8'h00;
    req = 4'b0100;
    @(negedge clk);
    check("midrst_issue_buy", 32'(pm_buy), 1);
    @(negedge clk);
    reset = 1'b1;
    req = '0;
    @(negedge clk);
    check("midrst_ack", 32'(ack), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_pm_buy", 32'(pm_buy), 0);
    check("midrst_pm_credit", 32'(pm_credit), 0);
    reset = 1'b0;
    req_product = 8'h55;
    req = 4'b1111;
    wait_ack(8'd0, 2'd0);
    check("midrst_first_grant", 32'(r_ack), 4'b0001);
    check("midrst_wallet0", 32'(r_cr), 0);
    check("midrst_grant_latency", r_bc, 1);

    // Deduction floors at zero
    deposit(2'd1, 8'd10);
    buy(1, PROD_APPLE, 3, 8'd0);
    check("floor_ok", 32'(r_ok), 1);
    buy(1, PROD_BANANA, 0, 8'd0);
    check("floor_wallet1", 32'(r_cr), 0);
    check("floor_refused", 32'(r_err), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
